// File: rtl/psum_pingpong_ctrl_pkg.sv
// rtl/psum_pingpong_ctrl_pkg.sv - shared types and sizes for the ping-pong psum controller
package psum_pingpong_ctrl_pkg;

   localparam int DATA_W     = 152;
   localparam int BANK_DEPTH = 8;
   localparam int WCNT_W     = $clog2(BANK_DEPTH);
   localparam int ADDR_W     = WCNT_W + 1;

   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(BANK_DEPTH - 1);

   typedef enum logic {EMPTY, FULL} bank_st_e;

   typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} gnt_e;

   // Round-robin between the two requesters; a lone requester always wins.
   function automatic gnt_e arbitrate(input logic wr_req, input logic rd_req, input gnt_e last);
      gnt_e g;
      if (wr_req && rd_req) begin
         g = (last == GNT_RD) ? GNT_WR : GNT_RD;
      end else if (wr_req) begin
         g = GNT_WR;
      end else if (rd_req) begin
         g = GNT_RD;
      end else begin
         g = GNT_NONE;
      end
      return g;
   endfunction

endpackage

// File: rtl/psum_pingpong_ctrl_if.sv
// rtl/psum_pingpong_ctrl_if.sv - stream and SRAM signal bundle for the ping-pong controller
interface psum_pingpong_ctrl_if;
   import psum_pingpong_ctrl_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [DATA_W-1:0] sram_D;
   logic [ADDR_W-1:0] sram_A;
   logic              sram_CEN_EVEN;
   logic              sram_WEN_EVEN;
   logic              sram_CEN_ODD;
   logic              sram_WEN_ODD;
   logic [DATA_W-1:0] sram_Q;
   logic [1:0]        bank_full;

   modport slave (
      input  in_valid, in_data, out_ready, sram_Q,
      output in_ready, out_valid, out_data, sram_D, sram_A,
             sram_CEN_EVEN, sram_WEN_EVEN, sram_CEN_ODD, sram_WEN_ODD, bank_full
   );

   modport master (
      output in_valid, in_data, out_ready, sram_Q,
      input  in_ready, out_valid, out_data, sram_D, sram_A,
             sram_CEN_EVEN, sram_WEN_EVEN, sram_CEN_ODD, sram_WEN_ODD, bank_full
   );

endinterface

// File: rtl/psum_pingpong_ctrl_skid_fifo2.sv
// rtl/psum_pingpong_ctrl_skid_fifo2.sv - two-entry FIFO catching SRAM read data ahead of the output port
module psum_skid_fifo2
   import psum_pingpong_ctrl_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              head_valid,
   output logic [DATA_W-1:0] head_data,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] mem_q [2];
   logic [DATA_W-1:0] mem_d [2];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;
   logic              do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != 2'd0);
      // A full FIFO may still take a push when its head leaves in the same cycle.
      do_push  = push && ((count_q != 2'd2) || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_valid = (count_q != 2'd0);
   assign head_data  = mem_q[rd_ptr_q];
   assign count      = count_q;

endmodule

// File: rtl/psum_pingpong_ctrl.sv
// rtl/psum_pingpong_ctrl.sv - fills one SRAM bank from the input stream while the other drains to the output
module psum_pingpong_ctrl
   import psum_pingpong_ctrl_pkg::*;
(
   input  logic                 CLK,
   input  logic                 RESET,
   psum_pingpong_ctrl_if.slave  io
);

   bank_st_e          bank_st_q [2];
   bank_st_e          bank_st_d [2];
   logic              fill_bank_q, fill_bank_d;
   logic              drain_bank_q, drain_bank_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [WCNT_W-1:0] rcnt_q, rcnt_d;
   logic              rd_pending_q, rd_pending_d;
   gnt_e              last_gnt_q, last_gnt_d;
   logic [ADDR_W-1:0] sram_a_q, sram_a_d;
   logic [DATA_W-1:0] sram_d_q, sram_d_d;

   gnt_e              gnt;
   logic              wr_req, rd_req;
   logic [1:0]        credit;
   logic              cen_even, wen_even, cen_odd, wen_odd;
   logic [1:0]        fifo_count;
   logic              fifo_valid;
   logic [DATA_W-1:0] fifo_head;

   always_comb begin
      wr_req = io.in_valid && (bank_st_q[fill_bank_q] == EMPTY);
      // Outstanding reads plus buffered words may never exceed the FIFO depth.
      credit = fifo_count + {1'b0, rd_pending_q};
      rd_req = (bank_st_q[drain_bank_q] == FULL) && (credit < 2'd2);
      gnt    = RESET ? GNT_NONE : arbitrate(wr_req, rd_req, last_gnt_q);

      bank_st_d    = bank_st_q;
      fill_bank_d  = fill_bank_q;
      drain_bank_d = drain_bank_q;
      wcnt_d       = wcnt_q;
      rcnt_d       = rcnt_q;
      rd_pending_d = 1'b0;
      last_gnt_d   = last_gnt_q;
      sram_a_d     = sram_a_q;
      sram_d_d     = sram_d_q;
      cen_even     = 1'b1;
      wen_even     = 1'b1;
      cen_odd      = 1'b1;
      wen_odd      = 1'b1;

      case (gnt)
         GNT_WR: begin
            sram_a_d = {fill_bank_q, wcnt_q};
            sram_d_d = io.in_data;
            if (fill_bank_q) begin
               cen_odd = 1'b0;
               wen_odd = 1'b0;
            end else begin
               cen_even = 1'b0;
               wen_even = 1'b0;
            end
            wcnt_d     = wcnt_q + WCNT_W'(1);
            last_gnt_d = GNT_WR;
            if (wcnt_q == WCNT_LAST) begin
               bank_st_d[fill_bank_q] = FULL;
               fill_bank_d            = ~fill_bank_q;
            end
         end
         GNT_RD: begin
            sram_a_d = {drain_bank_q, rcnt_q};
            if (drain_bank_q) begin
               cen_odd = 1'b0;
            end else begin
               cen_even = 1'b0;
            end
            rd_pending_d = 1'b1;
            rcnt_d       = rcnt_q + WCNT_W'(1);
            last_gnt_d   = GNT_RD;
            // Freed on issue: Q is captured at this edge, so a refill next cycle is safe.
            if (rcnt_q == WCNT_LAST) begin
               bank_st_d[drain_bank_q] = EMPTY;
               drain_bank_d            = ~drain_bank_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         bank_st_q[0] <= EMPTY;
         bank_st_q[1] <= EMPTY;
         fill_bank_q  <= 1'b0;
         drain_bank_q <= 1'b0;
         wcnt_q       <= '0;
         rcnt_q       <= '0;
         rd_pending_q <= 1'b0;
         last_gnt_q   <= GNT_RD;
         sram_a_q     <= '0;
         sram_d_q     <= '0;
      end else begin
         bank_st_q[0] <= bank_st_d[0];
         bank_st_q[1] <= bank_st_d[1];
         fill_bank_q  <= fill_bank_d;
         drain_bank_q <= drain_bank_d;
         wcnt_q       <= wcnt_d;
         rcnt_q       <= rcnt_d;
         rd_pending_q <= rd_pending_d;
         last_gnt_q   <= last_gnt_d;
         sram_a_q     <= sram_a_d;
         sram_d_q     <= sram_d_d;
      end
   end

   psum_skid_fifo2 u_fifo (
      .CLK        (CLK),
      .RESET      (RESET),
      .push       (rd_pending_q),
      .push_data  (io.sram_Q),
      .pop        (fifo_valid && io.out_ready),
      .head_valid (fifo_valid),
      .head_data  (fifo_head),
      .count      (fifo_count)
   );

   assign io.in_ready      = (gnt == GNT_WR);
   assign io.sram_A        = sram_a_d;
   assign io.sram_D        = sram_d_d;
   assign io.sram_CEN_EVEN = cen_even;
   assign io.sram_WEN_EVEN = wen_even;
   assign io.sram_CEN_ODD  = cen_odd;
   assign io.sram_WEN_ODD  = wen_odd;
   assign io.out_valid     = fifo_valid;
   assign io.out_data      = fifo_head;
   assign io.bank_full     = {bank_st_q[1] == FULL, bank_st_q[0] == FULL};

endmodule

// File: tb/tb_psum_pingpong_ctrl.sv
// tb/tb_psum_pingpong_ctrl.sv - randomized bench for psum_pingpong_ctrl against a block-count reference model
module tb_psum_pingpong_ctrl;
   import psum_pingpong_ctrl_pkg::*;

   logic CLK = 1'b0;
   logic RESET;

   psum_pingpong_ctrl_if io();

   psum_pingpong_ctrl dut (
      .CLK   (CLK),
      .RESET (RESET),
      .io    (io)
   );

   always #5 CLK = ~CLK;

   // Behavioural SRAM: enables pick the bank, A[2:0] the word, Q registered.
   logic [DATA_W-1:0] mem [16];
   logic [DATA_W-1:0] q_r;
   assign io.sram_Q = q_r;

   always @(posedge CLK) begin
      if (!io.sram_CEN_EVEN && !io.sram_WEN_EVEN) mem[{1'b0, io.sram_A[2:0]}] <= io.sram_D;
      if (!io.sram_CEN_ODD && !io.sram_WEN_ODD)   mem[{1'b1, io.sram_A[2:0]}] <= io.sram_D;
      if (!io.sram_CEN_EVEN && io.sram_WEN_EVEN)  q_r <= mem[{1'b0, io.sram_A[2:0]}];
      if (!io.sram_CEN_ODD && io.sram_WEN_ODD)    q_r <= mem[{1'b1, io.sram_A[2:0]}];
   end

   int n_chk = 0;
   int n_pass = 0;

   // Model state: W words accepted, R reads issued, P words delivered since reset.
   int                W, R, P;
   bit                pend, last_rd;
   logic [DATA_W-1:0] ref_q [$];
   logic [3:0]        prev_a;
   logic [DATA_W-1:0] prev_d;
   int                cyc = 0;
   int                acc_total = 0;
   int                rd_total = 0;
   int                pop_cyc [$];
   logic [DATA_W-1:0] pop_dat [$];
   logic [3:0]        wr_log [$];
   int                seq = 0;
   bit                use_rand = 0;

   task automatic chk(input bit ok, input string name, input logic [DATA_W-1:0] act,
                      input logic [DATA_W-1:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   function automatic logic [DATA_W-1:0] mk_word();
      logic [127:0] r;
      seq++;
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (!use_rand) r = '0;
      return {r, 24'(seq)};
   endfunction

   task automatic monitor_step();
      int                g;
      bit                wr_req, rd_req, ov;
      logic [3:0]        en_exp, a_exp;
      logic [DATA_W-1:0] d_exp, tmp;
      logic [1:0]        bf;
      cyc++;
      if (RESET === 1'b1) begin
         W = 0; R = 0; P = 0; pend = 0; last_rd = 1;
         ref_q.delete();
         prev_a = '0; prev_d = '0;
      end else begin
         // Block W/8 reuses the bank of block W/8-2, which must have been fully read.
         wr_req = (io.in_valid === 1'b1) && (R >= 8 * (W / 8 - 1));
         rd_req = (W >= 8 * (R / 8 + 1)) && ((R - P) < 2);
         if (wr_req && rd_req) g = last_rd ? 1 : 2;
         else if (wr_req)      g = 1;
         else if (rd_req)      g = 2;
         else                  g = 0;
         en_exp = 4'hF; a_exp = prev_a; d_exp = prev_d;
         if (g == 1) begin
            a_exp  = 4'(W % 16);
            d_exp  = io.in_data;
            en_exp = ((W / 8) % 2 == 0) ? 4'b0011 : 4'b1100;
         end else if (g == 2) begin
            a_exp  = 4'(R % 16);
            en_exp = ((R / 8) % 2 == 0) ? 4'b0111 : 4'b1101;
         end
         bf = 2'b00;
         for (int j = R / 8; j < W / 8; j++) bf[j % 2] = 1'b1;
         ov = (R - P - int'(pend)) > 0;

         chk(io.in_ready === (g == 1), "in_ready", io.in_ready, g == 1);
         chk({io.sram_CEN_EVEN, io.sram_WEN_EVEN, io.sram_CEN_ODD, io.sram_WEN_ODD} === en_exp,
             "sram_en", {io.sram_CEN_EVEN, io.sram_WEN_EVEN, io.sram_CEN_ODD, io.sram_WEN_ODD}, en_exp);
         chk(io.sram_A === a_exp, "sram_A", io.sram_A, a_exp);
         if (g != 2) chk(io.sram_D === d_exp, "sram_D", io.sram_D, d_exp);
         chk(io.bank_full === bf, "bank_full", io.bank_full, bf);
         chk(io.out_valid === ov, "out_valid", io.out_valid, ov);

         if (ov && io.out_ready === 1'b1) begin
            chk(ref_q.size() != 0, "out_nonempty", ref_q.size(), 1);
            if (ref_q.size() != 0) begin
               tmp = ref_q.pop_front();
               chk(io.out_data === tmp, "out_data", io.out_data, tmp);
            end
            P++;
            pop_cyc.push_back(cyc);
            pop_dat.push_back(io.out_data);
         end
         if (g == 1) begin
            ref_q.push_back(io.in_data);
            W++;
            acc_total++;
            wr_log.push_back(io.sram_A);
            prev_d = d_exp;
         end
         if (g == 2) begin
            R++;
            rd_total++;
         end
         pend = (g == 2);
         if (g != 0) last_rd = (g == 2);
         prev_a = a_exp;
      end
   endtask

   task automatic run_words(input int n, input int vpct, input int rpct, input int budget);
      int sent = 0;
      int c = 0;
      int seen = acc_total;
      io.in_data = mk_word();
      while (sent < n && c < budget) begin
         io.in_valid  = ($urandom_range(99) < vpct);
         io.out_ready = ($urandom_range(99) < rpct);
         @(posedge CLK); #1;
         c++;
         if (acc_total != seen) begin
            seen = acc_total;
            sent++;
            if (sent < n) io.in_data = mk_word();
         end
      end
      io.in_valid = 1'b0;
      chk(sent == n, "words_sent", sent, n);
   endtask

   task automatic drain(input int budget);
      int c = 0;
      io.out_ready = 1'b1;
      while (P != 8 * (W / 8) && c < budget) begin
         @(posedge CLK); #1;
         c++;
      end
      chk(P == 8 * (W / 8), "drain_done", P, 8 * (W / 8));
   endtask

   initial begin
      int ws, rb, ab, ps, gap, n;
      RESET        = 1'b1;
      io.in_valid  = 1'b1;
      io.in_data   = '1;
      io.out_ready = 1'b0;
      fork
         forever begin
            @(negedge CLK);
            monitor_step();
         end
      join_none

      repeat (2) @(posedge CLK);
      @(negedge CLK); #1;
      chk({io.sram_CEN_EVEN, io.sram_WEN_EVEN, io.sram_CEN_ODD, io.sram_WEN_ODD} === 4'hF,
          "rst_en", {io.sram_CEN_EVEN, io.sram_WEN_EVEN, io.sram_CEN_ODD, io.sram_WEN_ODD}, 4'hF);
      chk(io.sram_A === 4'd0, "rst_A", io.sram_A, 0);
      chk(io.sram_D === '0, "rst_D", io.sram_D, 0);
      chk(io.in_ready === 1'b0, "rst_in_ready", io.in_ready, 0);
      chk(io.out_valid === 1'b0, "rst_out_valid", io.out_valid, 0);
      chk(io.out_data === '0, "rst_out_data", io.out_data, 0);
      chk(io.bank_full === 2'b00, "rst_bank_full", io.bank_full, 0);
      @(posedge CLK); #1;
      RESET = 1'b0;
      io.in_valid = 1'b0;

      // Fill both banks with the consumer stalled.
      ws = wr_log.size(); rb = rd_total; ab = acc_total;
      run_words(16, 100, 0, 60);
      io.in_data = mk_word();
      io.in_valid = 1'b1;
      repeat (10) @(posedge CLK);
      @(negedge CLK); #1;
      chk(acc_total - ab == 16, "fill_count", acc_total - ab, 16);
      chk(io.in_ready === 1'b0, "word17_blocked", io.in_ready, 0);
      chk(io.bank_full === 2'b11, "both_full", io.bank_full, 2'b11);
      chk(rd_total - rb == 2, "reads_capped", rd_total - rb, 2);
      chk(wr_log.size() == ws + 16, "wr_log_len", wr_log.size(), ws + 16);
      if (wr_log.size() == ws + 16) begin
         chk(wr_log[ws] === 4'd0, "word1_addr", wr_log[ws], 0);
         chk(wr_log[ws + 8] === 4'd8, "word9_addr", wr_log[ws + 8], 8);
         chk(wr_log[ws + 15] === 4'd15, "word16_addr", wr_log[ws + 15], 15);
      end
      @(posedge CLK); #1;
      io.in_valid = 1'b0;

      // Drain both banks.
      ps = pop_dat.size();
      drain(80);
      @(negedge CLK); #1;
      chk(pop_dat.size() == ps + 16, "drain16_len", pop_dat.size(), ps + 16);
      if (pop_dat.size() == ps + 16) begin
         for (int i = 0; i < 16; i++) chk(pop_dat[ps + i] === DATA_W'(i + 1), "drain16_word", pop_dat[ps + i], i + 1);
         gap = 0;
         for (int i = ps + 1; i < ps + 16; i++)
            if (pop_cyc[i] - pop_cyc[i - 1] - 1 > gap) gap = pop_cyc[i] - pop_cyc[i - 1] - 1;
         chk(gap <= 1, "drain16_gap", gap, 1);
      end
      chk(io.bank_full === 2'b00, "drained_empty", io.bank_full, 0);
      @(posedge CLK); #1;

      // Streaming with both sides always ready.
      use_rand = 1;
      ps = pop_dat.size();
      run_words(64, 100, 100, 400);
      drain(100);
      chk(pop_dat.size() - ps == 64, "stream64_count", pop_dat.size() - ps, 64);

      // Random valid and ready.
      ps = pop_dat.size();
      run_words(40, 70, 50, 800);
      drain(200);
      chk(pop_dat.size() - ps == 40, "rand40_count", pop_dat.size() - ps, 40);

      // Asynchronous reset in the middle of a fill.
      run_words(5, 100, 0, 40);
      io.in_data = mk_word();
      io.in_valid = 1'b1;
      @(posedge CLK); #2;
      RESET = 1'b1;
      #1;
      chk({io.sram_CEN_EVEN, io.sram_WEN_EVEN, io.sram_CEN_ODD, io.sram_WEN_ODD} === 4'hF,
          "async_rst_en", {io.sram_CEN_EVEN, io.sram_WEN_EVEN, io.sram_CEN_ODD, io.sram_WEN_ODD}, 4'hF);
      chk(io.bank_full === 2'b00, "async_rst_full", io.bank_full, 0);
      chk(io.in_ready === 1'b0, "async_rst_ready", io.in_ready, 0);
      @(posedge CLK); #1;
      RESET = 1'b0;
      io.in_valid = 1'b0;
      ws = wr_log.size(); ps = pop_dat.size();
      run_words(8, 100, 0, 40);
      chk(wr_log.size() == ws + 8, "post_rst_wr_len", wr_log.size(), ws + 8);
      if (wr_log.size() == ws + 8)
         for (int i = 0; i < 8; i++) chk(wr_log[ws + i] === 4'(i), "post_rst_addr", wr_log[ws + i], i);
      drain(60);
      chk(pop_dat.size() - ps == 8, "post_rst_count", pop_dat.size() - ps, 8);

      // Refill immediately after the last read of a block.
      @(posedge CLK); #1;
      RESET = 1'b1;
      @(posedge CLK); #1;
      RESET = 1'b0;
      rb = rd_total;
      run_words(8, 100, 0, 40);
      io.out_ready = 1'b1;
      n = 0;
      while (rd_total < rb + 8 && n < 60) begin
         @(posedge CLK);
         n++;
      end
      chk(rd_total == rb + 8, "block_read", rd_total - rb, 8);
      #1;
      io.in_data = mk_word();
      io.in_valid = 1'b1;
      @(negedge CLK); #1;
      chk(io.in_ready === 1'b1, "w9_ready", io.in_ready, 1);
      chk(io.sram_A === 4'd8, "w9_addr", io.sram_A, 8);
      chk({io.sram_CEN_ODD, io.sram_WEN_ODD} === 2'b00, "w9_odd_en", {io.sram_CEN_ODD, io.sram_WEN_ODD}, 0);
      chk(io.bank_full[0] === 1'b0, "even_empty", io.bank_full[0], 0);
      @(posedge CLK); #1;
      io.in_valid = 1'b0;
      drain(60);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
